// File: rtl/ddr3_local_responder.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_local_responder
// Brief    : Behavioural DDR3 local-interface responder with a 64-bit backing
//            store. When DDR3_RESP_STALL_EN is defined, one stall cycle is
//            inserted after every 4 beats in WR and RD.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_local_responder #(
    parameter int MEM_AW   = 8,
    parameter int INIT_LAT = 16,
    parameter int RD_LAT   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        init_start,
    output logic        init_done,
    input  logic [3:0]  cmd,
    input  logic        cmd_valid,
    input  logic [25:0] addr,
    input  logic [4:0]  cmd_burst_cnt,
    output logic        cmd_rdy,
    output logic        datain_rdy,
    input  logic [63:0] write_data,
    input  logic [7:0]  data_mask,
    output logic [63:0] read_data,
    output logic        read_data_valid,
    output logic        wl_err
);

    localparam logic [2:0] C_ST_UNINIT = 3'd0;
    localparam logic [2:0] C_ST_INIT   = 3'd1;
    localparam logic [2:0] C_ST_IDLE   = 3'd2;
    localparam logic [2:0] C_ST_WR     = 3'd3;
    localparam logic [2:0] C_ST_RLAT   = 3'd4;
    localparam logic [2:0] C_ST_RD     = 3'd5;
    localparam logic [2:0] C_ST_NOP    = 3'd6;

    localparam logic [3:0] C_CMD_READ  = 4'b0001;
    localparam logic [3:0] C_CMD_WRITE = 4'b0010;
    localparam int         C_DEPTH     = 1 << MEM_AW;
    localparam logic [MEM_AW-1:0] C_PTR_ONE = MEM_AW'(1);

`ifdef DDR3_RESP_STALL_EN
    localparam logic C_STALL = 1'b1;
`else
    localparam logic C_STALL = 1'b0;
`endif

    logic [63:0]       r_mem [C_DEPTH];
    logic [2:0]        r_state;
    logic [7:0]        r_cnt;
    logic [MEM_AW-1:0] r_ptr;
    logic [6:0]        r_left;
    logic [1:0]        r_beat;
    logic              r_init_done;
    logic              r_cmd_rdy;
    logic              r_datain_rdy;
    logic              r_rd_valid;
    logic [63:0]       r_rd_data;

    logic [6:0]        w_beats;
    logic [MEM_AW-1:0] w_start;
    logic              w_wr_beat;
    logic              w_unused_addr;

    // Two 64-bit beats per BL8 x16 burst; a zero burst count means 32 bursts
    assign w_beats       = (cmd_burst_cnt == 5'd0) ? 7'd64 : {1'b0, cmd_burst_cnt, 1'b0};
    assign w_start       = addr[MEM_AW+1:2];
    assign w_wr_beat     = (r_state == C_ST_WR) && r_datain_rdy;
    assign w_unused_addr = ^{addr[25:MEM_AW+2], addr[1:0]};

    assign init_done       = r_init_done;
    assign cmd_rdy         = r_cmd_rdy;
    assign datain_rdy      = r_datain_rdy;
    assign read_data       = r_rd_data;
    assign read_data_valid = r_rd_valid;
    assign wl_err          = 1'b0;

    // Backing store survives reset so data can be read back after re-init
    always_ff @(posedge clk) begin
        if (w_wr_beat) begin
            for (int i = 0; i < 8; i++) begin
                if (!data_mask[i]) begin
                    r_mem[r_ptr][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= C_ST_UNINIT;
            r_cnt        <= 8'd0;
            r_ptr        <= '0;
            r_left       <= 7'd0;
            r_beat       <= 2'd0;
            r_init_done  <= 1'b0;
            r_cmd_rdy    <= 1'b0;
            r_datain_rdy <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= 64'd0;
        end else begin
            r_init_done <= 1'b0;
            case (r_state)
                C_ST_UNINIT: begin
                    if (init_start) begin
                        if (INIT_LAT <= 1) begin
                            r_init_done <= 1'b1;
                            r_state     <= C_ST_IDLE;
                        end else begin
                            r_cnt   <= 8'(INIT_LAT);
                            r_state <= C_ST_INIT;
                        end
                    end
                end
                C_ST_INIT: begin
                    if (r_cnt == 8'd2) begin
                        r_init_done <= 1'b1;
                        r_state     <= C_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                C_ST_IDLE: begin
                    if (cmd_valid && r_cmd_rdy) begin
                        r_cmd_rdy <= 1'b0;
                        r_ptr     <= w_start;
                        r_left    <= w_beats;
                        r_beat    <= 2'd0;
                        if (cmd == C_CMD_WRITE) begin
                            r_datain_rdy <= 1'b1;
                            r_state      <= C_ST_WR;
                        end else if (cmd == C_CMD_READ) begin
                            r_cnt   <= 8'(RD_LAT);
                            r_state <= C_ST_RLAT;
                        end else begin
                            r_state <= C_ST_NOP;
                        end
                    end else begin
                        r_cmd_rdy <= 1'b1;
                    end
                end
                C_ST_WR: begin
                    if (r_datain_rdy) begin
                        r_ptr  <= r_ptr + C_PTR_ONE;
                        r_left <= r_left - 7'd1;
                        r_beat <= r_beat + 2'd1;
                        if (r_left == 7'd1) begin
                            r_datain_rdy <= 1'b0;
                            r_cmd_rdy    <= 1'b1;
                            r_state      <= C_ST_IDLE;
                        end else if (C_STALL && (r_beat == 2'd3)) begin
                            r_datain_rdy <= 1'b0;
                        end
                    end else begin
                        r_datain_rdy <= 1'b1;
                    end
                end
                C_ST_RLAT: begin
                    // Leaving here issues beat 0 so it is visible RD_LAT cycles after acceptance
                    if (r_cnt == 8'd2) begin
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= r_mem[r_ptr];
                        r_ptr      <= r_ptr + C_PTR_ONE;
                        r_left     <= r_left - 7'd1;
                        r_beat     <= r_beat + 2'd1;
                        r_state    <= C_ST_RD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                C_ST_RD: begin
                    if (r_left == 7'd0) begin
                        r_rd_valid <= 1'b0;
                        r_cmd_rdy  <= 1'b1;
                        r_state    <= C_ST_IDLE;
                    end else if (C_STALL && r_rd_valid && (r_beat == 2'd0)) begin
                        r_rd_valid <= 1'b0;
                    end else begin
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= r_mem[r_ptr];
                        r_ptr      <= r_ptr + C_PTR_ONE;
                        r_left     <= r_left - 7'd1;
                        r_beat     <= r_beat + 2'd1;
                    end
                end
                C_ST_NOP: begin
                    r_cmd_rdy <= 1'b1;
                    r_state   <= C_ST_IDLE;
                end
                default: begin
                    r_state <= C_ST_UNINIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_local_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_local_responder
// Brief    : Directed and random traffic for ddr3_local_responder, checked by
//            a queue scoreboard against a word-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_local_responder;

    localparam int MEM_AW   = 8;
    localparam int INIT_LAT = 16;
    localparam int RD_LAT   = 4;
    localparam int DEPTH    = 1 << MEM_AW;

    logic        clk = 1'b0;
    logic        rstn;
    logic        init_start;
    logic        init_done;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic [25:0] addr;
    logic [4:0]  cmd_burst_cnt;
    logic        cmd_rdy;
    logic        datain_rdy;
    logic [63:0] write_data;
    logic [7:0]  data_mask;
    logic [63:0] read_data;
    logic        read_data_valid;
    logic        wl_err;

    always #5 clk = ~clk;

    ddr3_local_responder #(
        .MEM_AW   (MEM_AW),
        .INIT_LAT (INIT_LAT),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .init_start      (init_start),
        .init_done       (init_done),
        .cmd             (cmd),
        .cmd_valid       (cmd_valid),
        .addr            (addr),
        .cmd_burst_cnt   (cmd_burst_cnt),
        .cmd_rdy         (cmd_rdy),
        .datain_rdy      (datain_rdy),
        .write_data      (write_data),
        .data_mask       (data_mask),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .wl_err          (wl_err)
    );

    typedef struct {
        logic [63:0] data;
        int          acc;
        bit          first;
    } exp_t;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] model_mem [DEPTH];
    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [63:0] beat_data [64];
    logic [7:0]  beat_mask [64];
    logic [63:0] last_rd = '0;
    int          last_valid_cyc = 0;
    int          rd_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (bound expired) cycle=%0d", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid read beat pops one expected entry
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            last_rd = '0;
        end else if (read_data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=1 required=0 cycle=%0d", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("read_data", read_data, mon_e.data);
                if (mon_e.first)
                    check("read_latency", 64'(cyc - mon_e.acc), 64'(RD_LAT));
`ifndef DDR3_RESP_STALL_EN
                else
                    check("read_gap", 64'(cyc - last_valid_cyc), 64'd1);
`endif
            end
            last_rd        = read_data;
            last_valid_cyc = cyc;
            rd_seen++;
        end else begin
            check("read_hold", read_data, last_rd);
        end
    end

    task automatic issue(input logic [3:0] c, input logic [25:0] a, input logic [4:0] bc,
                         output int acc);
        int n;
        n = 0;
        cmd = c; addr = a; cmd_burst_cnt = bc; cmd_valid = 1'b1;
        while (!cmd_rdy && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_rdy) fail_now("accept_timeout");
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
        cmd = 4'($urandom); addr = 26'($urandom); cmd_burst_cnt = 5'($urandom);
        check("cmd_rdy_after_accept", 64'(cmd_rdy), 64'd0);
    endtask

    task automatic do_init(input bit hold_cmd);
        int c0, n;
        cmd = 4'b0001; addr = 26'h0; cmd_burst_cnt = 5'd1; cmd_valid = hold_cmd;
        init_start = 1'b1;
        c0 = cyc;
        tick();
        init_start = 1'b0;
        n = 0;
        while (!init_done && n < 300) begin
            check("init_cmd_rdy", 64'(cmd_rdy), 64'd0);
            tick();
            n++;
        end
        if (!init_done) fail_now("init_timeout");
        else check("init_latency", 64'(cyc - c0), 64'(INIT_LAT));
        cmd_valid = 1'b0;
        tick();
        check("init_pulse_width", 64'(init_done), 64'd0);
        check("init_then_cmd_rdy", 64'(cmd_rdy), 64'd1);
        check("init_no_datain", 64'(datain_rdy), 64'd0);
    endtask

    task automatic do_write(input logic [25:0] a, input logic [4:0] bc);
        int nb, acc, first_c, last_c, k, w;
        nb = (bc == 5'd0) ? 64 : 2 * int'(bc);
        issue(4'b0010, a, bc, acc);
        first_c = cyc;
        last_c  = cyc;
        for (int n = 0; n < nb; n++) begin
            k = 0;
            while (!datain_rdy && k < 8) begin
                tick();
                k++;
            end
            if (!datain_rdy) begin
                fail_now("write_beat_timeout");
                break;
            end
            if (n == 0) first_c = cyc;
            last_c = cyc;
            write_data = beat_data[n];
            data_mask  = beat_mask[n];
            w = (int'(a[MEM_AW+1:2]) + n) % DEPTH;
            for (int b = 0; b < 8; b++)
                if (!beat_mask[n][b]) model_mem[w][8*b +: 8] = beat_data[n][8*b +: 8];
            tick();
        end
        check("wr_first_beat", 64'(first_c - acc), 64'd1);
`ifndef DDR3_RESP_STALL_EN
        check("wr_beat_cycles", 64'(last_c - first_c + 1), 64'(nb));
`endif
        check("wr_rdy_drop", 64'(datain_rdy), 64'd0);
        check("wr_cmd_rdy_after", 64'(cmd_rdy), 64'd1);
        write_data = 64'($urandom);
        data_mask  = 8'($urandom);
    endtask

    task automatic queue_read(input logic [25:0] a, input logic [4:0] bc, input int acc);
        int nb;
        nb = (bc == 5'd0) ? 64 : 2 * int'(bc);
        for (int n = 0; n < nb; n++)
            exp_q.push_back('{data: model_mem[(int'(a[MEM_AW+1:2]) + n) % DEPTH],
                              acc: acc, first: (n == 0)});
    endtask

    task automatic do_read(input logic [25:0] a, input logic [4:0] bc);
        int acc, k;
        issue(4'b0001, a, bc, acc);
        queue_read(a, bc, acc);
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            fail_now("read_timeout");
            exp_q.delete();
        end
        tick();
        check("rd_valid_drop", 64'(read_data_valid), 64'd0);
        check("rd_cmd_rdy_after", 64'(cmd_rdy), 64'd1);
    endtask

    task automatic do_nop(input logic [3:0] c);
        int acc;
        issue(c, 26'($urandom), 5'($urandom), acc);
        check("nop_no_datain", 64'(datain_rdy), 64'd0);
        tick();
        check("nop_cmd_rdy_back", 64'(cmd_rdy), 64'd1);
        check("nop_no_datain2", 64'(datain_rdy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] ra;
        logic [4:0]  rb;
        logic [3:0]  nc;
        int          sel, acc, k;

        rstn = 1'b0; init_start = 1'b0; cmd = 4'd0; cmd_valid = 1'b0;
        addr = 26'd0; cmd_burst_cnt = 5'd0; write_data = 64'd0; data_mask = 8'd0;
        tick();
        tick();
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        check("rst_datain_rdy", 64'(datain_rdy), 64'd0);
        check("rst_rd_valid", 64'(read_data_valid), 64'd0);
        check("rst_wl_err", 64'(wl_err), 64'd0);
        check("rst_read_data", read_data, 64'd0);

        // Commands offered before initialisation must be ignored
        rstn = 1'b1; cmd = 4'b0010; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("uninit_cmd_rdy", 64'(cmd_rdy), 64'd0);
            check("uninit_datain", 64'(datain_rdy), 64'd0);
        end
        do_init(1'b1);

        for (int w = 0; w < 4; w++) begin
            for (int n = 0; n < 64; n++) begin
                beat_data[n] = {$urandom, $urandom};
                beat_mask[n] = 8'h00;
            end
            do_write(26'((w * 64) << 2), 5'd0);
        end

        beat_data[0] = 64'hA5A5_0000_0000_0001; beat_mask[0] = 8'h00;
        beat_data[1] = 64'hA5A5_0000_0000_0002; beat_mask[1] = 8'h00;
        do_write(26'h10, 5'd1);
        do_read(26'h10, 5'd1);

        beat_data[0] = 64'd0; beat_data[1] = 64'd0;
        do_write(26'h40, 5'd1);
        beat_data[0] = '1; beat_data[1] = '1;
        beat_mask[0] = 8'hF0; beat_mask[1] = 8'hF0;
        do_write(26'h40, 5'd1);
        do_read(26'h40, 5'd1);

        for (int n = 0; n < 64; n++) begin
            beat_data[n] = {$urandom, $urandom};
            beat_mask[n] = 8'h00;
        end
        ra = {16'h0ABC, 8'(DEPTH - 4), 2'b01};
        do_write(ra, 5'd0);
        do_read(ra, 5'd0);

        do_nop(4'b0110);

        for (int t = 0; t < 40; t++) begin
            ra  = 26'($urandom);
            rb  = 5'($urandom_range(0, 31));
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                for (int n = 0; n < 64; n++) begin
                    beat_data[n] = {$urandom, $urandom};
                    beat_mask[n] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                end
                do_write(ra, rb);
            end else if (sel < 9) begin
                do_read(ra, rb);
            end else begin
                nc = 4'($urandom_range(3, 15));
                do_nop(nc);
            end
        end

        // Reset in the middle of a read burst, then re-init and read back
        ra = 26'h0000_200;
        rd_seen = 0;
        issue(4'b0001, ra, 5'd4, acc);
        queue_read(ra, 5'd4, acc);
        k = 0;
        while (!(rd_seen == 3 && read_data_valid) && k < 50) begin
            @(posedge clk);
            #3;
            k++;
        end
        if (!(rd_seen == 3 && read_data_valid)) fail_now("mid_read_wait");
        rstn = 1'b0;
        #1;
        check("async_rst_valid", 64'(read_data_valid), 64'd0);
        check("async_rst_data", read_data, 64'd0);
        check("async_rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        exp_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("post_rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        do_init(1'b0);
        do_read(ra, 5'd4);
        do_read(26'h10, 5'd1);

        check("final_wl_err", 64'(wl_err), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
